// File: rtl/mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_pkg
//  Description : Shared types and sizing for the modular-reduction responder.
//                Holds the FSM state enum, default operand width / lane count
//                and the per-request iteration count.
//  Macros      : MOD_RADIX4_EN - two conditional-subtract steps per ITER
//                cycle (16 iterations) instead of one (32 iterations).
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_pkg;

  localparam int MOD_WIDTH = 32;
  localparam int MOD_LANES = 3;

`ifdef MOD_RADIX4_EN
  localparam int MOD_STEPS = 2;
`else
  localparam int MOD_STEPS = 1;
`endif

  localparam int MOD_ITERS = MOD_WIDTH / MOD_STEPS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ITER    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } mod_state_e;

endpackage
`default_nettype wire

// File: rtl/mod_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_responder_if
//  Description : Request/result bundle between the custom-instruction
//                controller (master) and the mod responder (slave).
//  Signals     : custom_mod        - request level (master -> slave)
//                custom_op_a       - LANES dividends (master -> slave)
//                custom_op_b       - shared modulus (master -> slave)
//                custom_mod_result - LANES remainders (slave -> master)
//                mod_valid         - one-cycle result strobe (slave -> master)
//                mod_busy          - responder occupied (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_responder_if
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH,
  parameter int LANES = MOD_LANES
);

  logic                          custom_mod;
  logic [LANES-1:0][WIDTH-1:0]   custom_op_a;
  logic [WIDTH-1:0]              custom_op_b;
  logic [LANES-1:0][WIDTH-1:0]   custom_mod_result;
  logic                          mod_valid;
  logic                          mod_busy;

  modport master (
    output custom_mod, custom_op_a, custom_op_b,
    input  custom_mod_result, mod_valid, mod_busy
  );

  modport slave (
    input  custom_mod, custom_op_a, custom_op_b,
    output custom_mod_result, mod_valid, mod_busy
  );

endinterface
`default_nettype wire

// File: rtl/mod_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mod_lane
//  Description : One lane of the shift-subtract reducer: dividend shift
//                register, (WIDTH+1)-bit remainder register and STEPS chained
//                conditional-subtract stages evaluated per step_i cycle.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                load_i       - capture dividend_i into the shift register
//                clear_i      - zero the remainder register
//                step_i       - advance the reduction by STEPS bits
//                dividend_i   - dividend to capture
//                modulus_i    - latched modulus (held by the controller)
//                rem_next_o   - remainder after this cycle's step(s)
//                dividend_o   - current dividend register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_lane #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] modulus_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic [WIDTH-1:0] dividend_o
);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   w_rem_step;
  logic [WIDTH-1:0] w_div_step;

  // Chained restoring steps. The remainder stays below the modulus between
  // steps, so the shifted value is < 2*modulus and one subtract suffices;
  // the extra remainder bit holds the shifted-out MSB for that compare.
  always_comb begin
    w_rem_step = rem_q;
    w_div_step = div_q;
    for (int s = 0; s < STEPS; s++) begin
      w_rem_step = {w_rem_step[WIDTH-1:0], w_div_step[WIDTH-1]};
      if (w_rem_step >= {1'b0, modulus_i}) begin
        w_rem_step = w_rem_step - {1'b0, modulus_i};
      end
      w_div_step = {w_div_step[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    if (load_i) begin
      div_d = dividend_i;
    end
    if (clear_i) begin
      rem_d = '0;
    end
    if (step_i) begin
      rem_d = w_rem_step;
      div_d = w_div_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
    end
  end

  assign rem_next_o = w_rem_step[WIDTH-1:0];
  assign dividend_o = div_q;

endmodule
`default_nettype wire

// File: rtl/mod_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mod_responder
//  Description : Multi-lane modular-reduction responder. Latches LANES
//                dividends and one modulus on a level request, reduces every
//                lane with a shared-counter shift-subtract, then presents all
//                remainders with a single-cycle mod_valid strobe. A zero
//                modulus passes the dividends straight through.
//  Ports       : clk   - clock
//                rst_n - async active-low reset
//                bus   - mod_responder_if.slave (request in, result out)
//  Macros      : MOD_RADIX4_EN - two subtract steps per cycle (via mod_pkg).
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_responder
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH,
  parameter int LANES = MOD_LANES
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_responder_if.slave bus
);

  localparam int               ITERS      = WIDTH / MOD_STEPS;
  localparam int               CNT_W      = $clog2(ITERS);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  mod_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            modulus_q, modulus_d;
  logic [LANES-1:0][WIDTH-1:0] result_q, result_d;
  logic [LANES-1:0][WIDTH-1:0] w_lane_rem;
  logic [LANES-1:0][WIDTH-1:0] w_lane_div;
  logic                        w_load, w_clear, w_step, w_busy, w_valid;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  // A dropped request in LOAD/ITER aborts before any completion check.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.custom_mod) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.custom_mod)       state_d = ST_IDLE;
        else if (modulus_q == '0)  state_d = ST_DONE;
        else                       state_d = ST_ITER;
      end
      ST_ITER: begin
        if (!bus.custom_mod)          state_d = ST_IDLE;
        else if (cnt_q == C_CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.custom_mod) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_load  = (state_q == ST_IDLE) && bus.custom_mod;
    w_clear = (state_q == ST_LOAD);
    w_step  = (state_q == ST_ITER);
    w_busy  = (state_q != ST_IDLE);
    w_valid = (state_q == ST_DONE);
  end

  // ----------------------------------------------------------------- datapath
  // The result register only moves on entry to DONE: from the final step's
  // remainders, or straight from the untouched dividends for a zero modulus.
  always_comb begin
    modulus_d = modulus_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (w_load) begin
      modulus_d = bus.custom_op_b;
    end
    if (w_clear) begin
      cnt_d = '0;
    end else if (w_step) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end
    if (state_d == ST_DONE) begin
      if (state_q == ST_LOAD) begin
        result_d = w_lane_div;
      end else if (state_q == ST_ITER) begin
        result_d = w_lane_rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modulus_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      modulus_q <= modulus_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // -------------------------------------------------------------------- lanes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mod_lane #(
      .WIDTH (WIDTH),
      .STEPS (MOD_STEPS)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (w_load),
      .clear_i    (w_clear),
      .step_i     (w_step),
      .dividend_i (bus.custom_op_a[l]),
      .modulus_i  (modulus_q),
      .rem_next_o (w_lane_rem[l]),
      .dividend_o (w_lane_div[l])
    );
  end

  assign bus.custom_mod_result = result_q;
  assign bus.mod_valid         = w_valid;
  assign bus.mod_busy          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mod_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_responder
//  Description : Self-checking bench for mod_responder. Table-driven request
//                vectors (fixed and random) checked against a plain-arithmetic
//                remainder model, plus hand sequences for hold, abort and
//                mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_responder;

`ifdef MOD_RADIX4_EN
  localparam int ITERS = 16;
`else
  localparam int ITERS = 32;
`endif
  localparam int NVEC = 10;

  typedef struct packed {
    logic [2:0][31:0] a;
    logic [31:0]      b;
    logic [2:0][31:0] e;
    logic [7:0]       hold;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2:0][31:0] prev_res;
  vec_t vecs [NVEC];

  mod_responder_if #(.WIDTH(32), .LANES(3)) bus ();

  mod_responder #(.WIDTH(32), .LANES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mod(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : (a % b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Issue one request and follow it to completion. k counts edges after the
  // sampling edge T, so mod_valid is expected at k = ITERS+1 (or 1 when the
  // modulus is zero).
  task automatic run_req(input vec_t v);
    int k;
    int strobes;
    int low_busy;
    @(negedge clk);
    bus.custom_op_a = v.a;
    bus.custom_op_b = v.b;
    bus.custom_mod  = 1'b1;
    k = -1;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 0) chk("busy_load", {63'd0, bus.mod_busy}, 64'd1);
      if (k == 1) begin
        bus.custom_op_a = {$urandom, $urandom, $urandom};
        bus.custom_op_b = $urandom;
      end
    end while (!bus.mod_valid && k < 100);
    chk("latency", 64'(k), (v.b == 32'd0) ? 64'd1 : 64'(ITERS + 1));
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("result_l%0d", l), {32'd0, bus.custom_mod_result[l]}, {32'd0, v.e[l]});
    end
    prev_res = v.e;
    strobes  = 0;
    low_busy = 0;
    for (int h = 0; h < int'(v.hold); h++) begin
      @(posedge clk); #1;
      if (bus.mod_valid) strobes++;
      if (!bus.mod_busy) low_busy++;
    end
    if (v.hold != 8'd0) begin
      chk("hold_strobes", 64'(strobes), 64'd0);
      chk("hold_busy", 64'(low_busy), 64'd0);
    end
    bus.custom_mod = 1'b0;
    @(posedge clk); #1;
    if (v.hold != 8'd0) chk("release_idle", {63'd0, bus.mod_busy}, 64'd0);
    @(posedge clk); #1;
    chk("idle_after", {63'd0, bus.mod_busy}, 64'd0);
  endtask

  initial begin
    int k;
    int strobes;
    total           = 0;
    bad             = 0;
    prev_res        = '0;
    rst_n           = 1'b0;
    bus.custom_mod  = 1'b0;
    bus.custom_op_a = '0;
    bus.custom_op_b = '0;

    // Fixed vectors with hand-derived remainders, then random ones from the model.
    vecs[0] = '{a: {32'd3, 32'hFFFF_FFFF, 32'd100}, b: 32'd7,
                e: {32'd3, 32'd3, 32'd2}, hold: 8'd10};
    vecs[1] = '{a: {32'd0, 32'd34, 32'd17}, b: 32'd17,
                e: {32'd0, 32'd0, 32'd0}, hold: 8'd0};
    vecs[2] = '{a: {32'hDEAD_BEEF, 32'd9, 32'd5}, b: 32'd0,
                e: {32'hDEAD_BEEF, 32'd9, 32'd5}, hold: 8'd2};
    vecs[3] = '{a: {32'hFFFF_FFFF, 32'h8000_0000, 32'd1}, b: 32'hFFFF_FFFF,
                e: {32'd0, 32'h8000_0000, 32'd1}, hold: 8'd0};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].a    = {$urandom, $urandom, 32'($urandom_range(0, 1000))};
      case (i % 3)
        0:       vecs[i].b = 32'($urandom_range(1, 20));
        1:       vecs[i].b = $urandom;
        default: vecs[i].b = 32'd1;
      endcase
      for (int l = 0; l < 3; l++) vecs[i].e[l] = ref_mod(vecs[i].a[l], vecs[i].b);
      vecs[i].hold = 8'($urandom_range(0, 3));
    end

    #2;
    chk("rst_result", {32'd0, bus.custom_mod_result[0] | bus.custom_mod_result[1] |
                       bus.custom_mod_result[2]}, 64'd0);
    chk("rst_valid", {63'd0, bus.mod_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.mod_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_req(vecs[i]);

    // Abort: request dropped so that edge T+10 samples it low.
    @(negedge clk);
    bus.custom_op_a = {32'd3000, 32'd2000, 32'd1000};
    bus.custom_op_b = 32'd13;
    bus.custom_mod  = 1'b1;
    k = -1;
    strobes = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (bus.mod_valid) strobes++;
    end while (k < 9);
    bus.custom_mod = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.mod_valid) strobes++;
    end
    chk("abort_strobes", 64'(strobes), 64'd0);
    chk("abort_busy", {63'd0, bus.mod_busy}, 64'd0);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("abort_keep_l%0d", l), {32'd0, bus.custom_mod_result[l]}, {32'd0, prev_res[l]});
    end
    run_req('{a: {32'd12, 32'd11, 32'd10}, b: 32'd4, e: {32'd0, 32'd3, 32'd2}, hold: 8'd1});

    // Reset mid-operation: outputs clear asynchronously, nothing follows.
    @(negedge clk);
    bus.custom_op_a = {32'd77, 32'd55, 32'd33};
    bus.custom_op_b = 32'd10;
    bus.custom_mod  = 1'b1;
    k = -1;
    do begin
      @(posedge clk); #1;
      k++;
    end while (k < 19);
    rst_n          = 1'b0;
    bus.custom_mod = 1'b0;
    #1;
    chk("mrst_result", {32'd0, bus.custom_mod_result[0] | bus.custom_mod_result[1] |
                        bus.custom_mod_result[2]}, 64'd0);
    chk("mrst_valid", {63'd0, bus.mod_valid}, 64'd0);
    chk("mrst_busy", {63'd0, bus.mod_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.mod_valid || bus.mod_busy) strobes++;
    end
    chk("mrst_quiet", 64'(strobes), 64'd0);

    // Recovery after reset.
    run_req('{a: {32'd77, 32'd55, 32'd33}, b: 32'd10, e: {32'd7, 32'd5, 32'd3}, hold: 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_responder.md
# mod_responder

Multi-lane modular-reduction responder serving the custom-instruction datapath's `mod` operation. It accepts a level-held request carrying three 32-bit operands and one modulus. It computes each `operand mod modulus` with an iterative shift-subtract, then returns all lanes with a single-cycle `mod_valid` pulse. It sits beside the custom-instruction controller as the other end of its mod request/result interface.

## Interface
- `WIDTH`, 32, operand/modulus/result bit width.
- `LANES`, 3, number of parallel operands/results.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `custom_mod`  in  1  request level; held high with operands stable until `mod_valid` is seen.
- `custom_op_a`  in  WIDTH x [LANES-1:0]  dividends, unsigned.
- `custom_op_b`  in  WIDTH  modulus, unsigned.
- `custom_mod_result`  out  WIDTH x [LANES-1:0]  remainders, registered.
- `mod_valid`  out  1  one-cycle result strobe.
- `mod_busy`  out  1  high in LOAD/ITER/DONE/RELEASE.

## Operation
- States: IDLE, LOAD, ITER, DONE, RELEASE.
- IDLE: if `custom_mod`=1 at an edge, latch all `custom_op_a` lanes and `custom_op_b`, go to LOAD.
- LOAD: clear per-lane remainder registers (WIDTH+1 bits) and the iteration counter.
  - If the latched modulus is 0, go directly to DONE with result = latched dividend (pass-through).
  - Otherwise go to ITER.
- ITER, per step and per lane:
  - rem = {rem[WIDTH-1:0], dividend MSB}; dividend <<= 1.
  - If rem >= modulus, rem -= modulus.
  - Counter increments; leave ITER after ITERS cycles, where ITERS = WIDTH / steps-per-cycle.
- DONE: drive `custom_mod_result` from the remainders and assert `mod_valid` for exactly this one cycle. Then go to RELEASE.
- RELEASE: wait for `custom_mod`=0, then go to IDLE. A held request is never recomputed.
- Abort: `custom_mod`=0 sampled in LOAD or ITER returns to IDLE. No `mod_valid` is issued and `custom_mod_result` is unchanged.
- Operands change while busy: ignored. Only the values latched in IDLE are used.
- All lanes share the counter and finish on the same cycle.

## Timing
- Reset values: `custom_mod_result` all lanes 0, `mod_valid` 0, `mod_busy` 0, state IDLE, counter 0.
- Asserting `rst_n`=0 mid-operation returns to IDLE immediately, with no pending strobe.
- Request sampled at edge T:
  - LOAD occupies cycle T+1.
  - ITER occupies T+2 .. T+1+ITERS.
  - `mod_valid` is high during cycle T+2+ITERS.
  - Radix-2: `mod_valid` at T+34.
- Zero modulus: `mod_valid` at T+2.
- `custom_mod_result` changes only on entry to DONE and is held until the next DONE.
- Minimum back-to-back spacing: the requester drops `custom_mod` for at least one sampled edge between requests.

## Configuration
- `MOD_RADIX4_EN` defined: two chained conditional-subtract steps per ITER cycle. ITERS=16, so a non-zero-modulus `mod_valid` arrives at T+18.
- `MOD_RADIX4_EN` undefined: one step per cycle. ITERS=32, `mod_valid` at T+34.
- Results are bit-identical in both builds. Only latency differs.

## Structure
- Package `mod_pkg` holds:
  - the state enum typedef;
  - `MOD_WIDTH`=32 and `MOD_LANES`=3 defaults;
  - the ITERS localparam, selected by `MOD_RADIX4_EN`.
- Sub-module `mod_lane`: one lane's dividend shift register, remainder register and conditional-subtract step(s). It is instantiated LANES times under the shared FSM and counter.

## Test plan
- Lanes {100, 0xFFFFFFFF, 3}, modulus 7 -> results {2, 3, 3}. `mod_valid` one cycle at T+34 (T+18 radix-4).
- Lanes {17, 34, 0}, modulus 17 -> results {0, 0, 0}.
- Modulus 0, lanes {5, 9, 0xDEADBEEF} -> results equal inputs, `mod_valid` at T+2.
- `custom_mod` held high 10 cycles after `mod_valid`:
  - exactly one strobe;
  - `mod_busy` stays high until `custom_mod` drops, then IDLE.
- `custom_mod` dropped at T+10 -> no `mod_valid`, previous results retained. A new request, lanes {10, 11, 12} mod 4, returns {2, 3, 0}.
- `rst_n` pulsed low at T+20 -> all outputs 0 immediately, no strobe after release.
